// File: rtl/qbus_pkg.sv
// rtl/qbus_pkg.sv - shared QBUS master types, default timing constants and lane helper.
package qbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_SYNC,
    ST_WSET,
    ST_DREQ,
    ST_TERM,
    ST_DONE
  } qbus_state_e;

  localparam int unsigned QBUS_ADDR_SETUP = 1;
  localparam int unsigned QBUS_DATA_SETUP = 1;
  localparam int unsigned QBUS_TIMEOUT    = 255;

  localparam logic [15:0] QBUS_IDLE_BUS = 16'hFFFF;

  // Byte writes put the low byte on both lanes; the responder picks one with addr[0].
  function automatic logic [15:0] qbus_lane_data(input logic bt, input logic [15:0] wdata);
    return bt ? {wdata[7:0], wdata[7:0]} : wdata;
  endfunction

endpackage

// File: rtl/qbus_rply_sync.sv
// rtl/qbus_rply_sync.sv - two-flop synchronizer for the asynchronous RPLY strobe.
module qbus_rply_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic rply_n_i,
  output logic rply_n_o
);

  logic meta_q;
  logic sync_q;

  // Both stages reset to 1 so a reset never looks like a reply.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rply_n_i;
      sync_q <= meta_q;
    end
  end

  assign rply_n_o = sync_q;

endmodule

// File: rtl/qbus_master.sv
// rtl/qbus_master.sv - QBUS single-word initiator for reads, word writes and byte writes.
// Optional RPLY timeout (and the TIMEOUT parameter) enabled by defining QBUS_MASTER_TIMEOUT_EN.
module qbus_master
  import qbus_pkg::*;
#(
  parameter int unsigned ADDR_SETUP = QBUS_ADDR_SETUP,
  parameter int unsigned DATA_SETUP = QBUS_DATA_SETUP
`ifdef QBUS_MASTER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT    = QBUS_TIMEOUT
`endif
) (
  input  logic        pin_clk,
  input  logic        pin_dclo_n,
  input  logic        req,
  input  logic        we,
  input  logic        bt,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  input  logic [15:0] ad_in,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  output logic        sync_n,
  output logic        din_n,
  output logic        dout_n,
  output logic        wtbt_n,
  input  logic        rply_n
);

  localparam int unsigned SW = 4;

  qbus_state_e   state_q;
  logic          we_q;
  logic          bt_q;
  logic [15:0]   data_q;
  logic [SW-1:0] setup_cnt_q;
  logic          ack_q;
  logic [15:0]   rdata_q;
  logic [15:0]   ad_out_q;
  logic          ad_oe_q;
  logic          sync_n_q;
  logic          din_n_q;
  logic          dout_n_q;
  logic          wtbt_n_q;
  logic          rply_n_s;
  logic          dreq_expire;
  logic          term_exit;

  qbus_rply_sync u_rply_sync (
    .clk_i    (pin_clk),
    .rst_n_i  (pin_dclo_n),
    .rply_n_i (rply_n),
    .rply_n_o (rply_n_s)
  );

`ifdef QBUS_MASTER_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmo_q;
  logic          tmo_err_q;
  logic          err_q;
  assign dreq_expire = (tmo_q == TW'(TIMEOUT - 1));
  assign term_exit   = rply_n_s || (tmo_q == TW'(TIMEOUT - 1));
  assign err         = err_q;
`else
  assign dreq_expire = 1'b0;
  assign term_exit   = rply_n_s;
  assign err         = 1'b0;
`endif

  always_ff @(posedge pin_clk) begin
    if (!pin_dclo_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      bt_q        <= 1'b0;
      data_q      <= '0;
      setup_cnt_q <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      ad_out_q    <= QBUS_IDLE_BUS;
      ad_oe_q     <= 1'b0;
      sync_n_q    <= 1'b1;
      din_n_q     <= 1'b1;
      dout_n_q    <= 1'b1;
      wtbt_n_q    <= 1'b1;
`ifdef QBUS_MASTER_TIMEOUT_EN
      tmo_q       <= '0;
      tmo_err_q   <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
`ifdef QBUS_MASTER_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            we_q        <= we;
            bt_q        <= bt;
            data_q      <= qbus_lane_data(bt, wdata);
            ad_out_q    <= ~addr;
            ad_oe_q     <= 1'b1;
            wtbt_n_q    <= ~we;
            setup_cnt_q <= '0;
            state_q     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (setup_cnt_q == SW'(ADDR_SETUP - 1)) begin
            sync_n_q    <= 1'b0;
            setup_cnt_q <= '0;
            state_q     <= ST_SYNC;
          end else begin
            setup_cnt_q <= setup_cnt_q + 1'b1;
          end
        end
        ST_SYNC: begin
          if (we_q) begin
            ad_out_q <= ~data_q;
            wtbt_n_q <= ~bt_q;
            state_q  <= ST_WSET;
          end else begin
            ad_oe_q  <= 1'b0;
            din_n_q  <= 1'b0;
            state_q  <= ST_DREQ;
`ifdef QBUS_MASTER_TIMEOUT_EN
            tmo_q    <= '0;
`endif
          end
        end
        ST_WSET: begin
          if (setup_cnt_q == SW'(DATA_SETUP - 1)) begin
            dout_n_q    <= 1'b0;
            setup_cnt_q <= '0;
            state_q     <= ST_DREQ;
`ifdef QBUS_MASTER_TIMEOUT_EN
            tmo_q       <= '0;
`endif
          end else begin
            setup_cnt_q <= setup_cnt_q + 1'b1;
          end
        end
        ST_DREQ: begin
          if (!rply_n_s || dreq_expire) begin
            // Write data stays on the bus through TERM for trailing-edge latching responders.
            din_n_q  <= 1'b1;
            dout_n_q <= 1'b1;
            state_q  <= ST_TERM;
            if (!rply_n_s && !we_q) begin
              rdata_q <= ~ad_in;
            end
`ifdef QBUS_MASTER_TIMEOUT_EN
            tmo_q <= '0;
            if (rply_n_s) begin
              tmo_err_q <= 1'b1;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        ST_TERM: begin
          if (term_exit) begin
            sync_n_q <= 1'b1;
            ad_oe_q  <= 1'b0;
            ad_out_q <= QBUS_IDLE_BUS;
            wtbt_n_q <= 1'b1;
            ack_q    <= 1'b1;
            state_q  <= ST_DONE;
`ifdef QBUS_MASTER_TIMEOUT_EN
            err_q    <= tmo_err_q || !rply_n_s;
          end else begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
`ifdef QBUS_MASTER_TIMEOUT_EN
          tmo_err_q <= 1'b0;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack    = ack_q;
  assign rdata  = rdata_q;
  assign ad_out = ad_out_q;
  assign ad_oe  = ad_oe_q;
  assign sync_n = sync_n_q;
  assign din_n  = din_n_q;
  assign dout_n = dout_n_q;
  assign wtbt_n = wtbt_n_q;

endmodule
